// File: rtl/sync_updown_counter_if.sv
// Control/status bundle for the synchronous up/down counter.
// The master drives the counting and snapshot controls; the slave (the counter)
// returns the count, flags and the snapshot.
interface sync_updown_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             control;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             clr_ovf;
    logic             snap_req;
    logic             snap_ack;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             wrap;
    logic             ovf_sticky;
    logic             snap_valid;
    logic [WIDTH-1:0] snap_data;

    modport master (
        output en, control, load, load_val, clr_ovf, snap_req, snap_ack,
        input  q, tc, wrap, ovf_sticky, snap_valid, snap_data
    );

    modport slave (
        input  en, control, load, load_val, clr_ovf, snap_req, snap_ack,
        output q, tc, wrap, ovf_sticky, snap_valid, snap_data
    );
endinterface

// File: rtl/sync_updown_counter.sv
// Synchronous loadable up/down counter over 0..MAX_VAL with terminal-count
// detection, a registered wrap pulse, a sticky overflow flag and a
// valid/ack snapshot port that freezes a copy of the count.
module sync_updown_counter #(
    parameter int WIDTH   = 4,
    parameter int MAX_VAL = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    sync_updown_counter_if.slave  bus
);
    localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);

    typedef enum logic {IDLE, HOLD} snap_st_e;

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             wrap_q, wrap_d;
    logic             ovf_q, ovf_d;
    logic             tc;
    snap_st_e         st_q, st_d;
    logic             sv_q, sv_d;
    logic [WIDTH-1:0] sd_q, sd_d;

    // Terminal count depends on the current direction, so it is purely combinational.
    always_comb begin
        tc = bus.control ? (cnt_q == '0) : (cnt_q == MAX_C);
    end

    // Counter next state: load beats enable; loads saturate at MAX_VAL and never wrap.
    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        if (bus.load) begin
            cnt_d = (bus.load_val > MAX_C) ? MAX_C : bus.load_val;
        end else if (bus.en) begin
            wrap_d = tc;
            if (bus.control)
                cnt_d = (cnt_q == '0) ? MAX_C : cnt_q - 1'b1;
            else
                cnt_d = (cnt_q == MAX_C) ? '0 : cnt_q + 1'b1;
        end
        // A wrap on the same edge as a clear keeps the flag set.
        ovf_d = wrap_d | (ovf_q & ~bus.clr_ovf);
    end

    // Counter, wrap pulse and overflow flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            wrap_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
            ovf_q  <= ovf_d;
        end
    end

    // Snapshot FSM: IDLE captures the pre-edge count on a request, HOLD keeps it
    // frozen until the consumer acks. A request coincident with the ack is dropped.
    always_comb begin
        st_d = st_q;
        sv_d = sv_q;
        sd_d = sd_q;
        case (st_q)
            IDLE: begin
                if (bus.snap_req) begin
                    sd_d = cnt_q;
                    sv_d = 1'b1;
                    st_d = HOLD;
                end
            end
            HOLD: begin
                if (bus.snap_ack) begin
                    sv_d = 1'b0;
                    st_d = IDLE;
                end
            end
            default: begin
                sv_d = 1'b0;
                st_d = IDLE;
            end
        endcase
    end

    // Snapshot state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q <= IDLE;
            sv_q <= 1'b0;
            sd_q <= '0;
        end else begin
            st_q <= st_d;
            sv_q <= sv_d;
            sd_q <= sd_d;
        end
    end

    assign bus.q          = cnt_q;
    assign bus.tc         = tc;
    assign bus.wrap       = wrap_q;
    assign bus.ovf_sticky = ovf_q;
    assign bus.snap_valid = sv_q;
    assign bus.snap_data  = sd_q;
endmodule

// File: tb/tb_sync_updown_counter.sv
// Scoreboard bench: each driven cycle pushes the expected post-edge state,
// which is popped and compared one edge later. A second instance built with
// MAX_VAL=9 covers load saturation.
module tb_sync_updown_counter;
    localparam int W   = 4;
    localparam int MAX = 15;

    typedef struct {
        logic [W-1:0] q;
        logic         wrap;
        logic         ovf;
        logic         sv;
        logic [W-1:0] sd;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sync_updown_counter_if #(.WIDTH(W)) bus ();
    sync_updown_counter_if #(.WIDTH(W)) bus9 ();

    sync_updown_counter #(.WIDTH(W), .MAX_VAL(MAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    sync_updown_counter #(.WIDTH(W), .MAX_VAL(9)) dut9 (
        .clk (clk),
        .rst (rst),
        .bus (bus9)
    );

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb_q[$];

    // model state
    logic [W-1:0] m_q;
    logic         m_wrap, m_ovf, m_sv;
    logic [W-1:0] m_sd;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q = '0; m_wrap = 1'b0; m_ovf = 1'b0; m_sv = 1'b0; m_sd = '0;
        sb_q.delete();
    endtask

    // Drive one cycle, predict, push; wait the edge, pop, compare.
    task automatic step(input logic en, input logic ctl, input logic ld, input logic [W-1:0] lv,
                        input logic clr, input logic sreq, input logic sack);
        logic m_tc;
        exp_t e, p;
        bus.en = en; bus.control = ctl; bus.load = ld; bus.load_val = lv;
        bus.clr_ovf = clr; bus.snap_req = sreq; bus.snap_ack = sack;
        #1;
        m_tc = ctl ? (m_q == 0) : (m_q == W'(MAX));
        chk("tc", bus.tc, m_tc);
        e.q = m_q;
        if (ld) e.q = (lv > W'(MAX)) ? W'(MAX) : lv;
        else if (en) begin
            if (ctl) e.q = (m_q == 0) ? W'(MAX) : m_q - 1'b1;
            else     e.q = (m_q == W'(MAX)) ? '0 : m_q + 1'b1;
        end
        e.wrap = en & ~ld & m_tc;
        e.ovf  = e.wrap | (m_ovf & ~clr);
        e.sv = m_sv; e.sd = m_sd;
        if (!m_sv && sreq) begin e.sv = 1'b1; e.sd = m_q; end
        else if (m_sv && sack) e.sv = 1'b0;
        sb_q.push_back(e);
        m_q = e.q; m_wrap = e.wrap; m_ovf = e.ovf; m_sv = e.sv; m_sd = e.sd;
        @(posedge clk);
        #1;
        p = sb_q.pop_front();
        chk("q", bus.q, p.q);
        chk("wrap", bus.wrap, p.wrap);
        chk("ovf", bus.ovf_sticky, p.ovf);
        chk("snap_valid", bus.snap_valid, p.sv);
        chk("snap_data", bus.snap_data, p.sd);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, '0, 0, 0, 0);
    endtask

    // Asynchronous reset pulse between edges; outputs must clear without a clock.
    task automatic rst_pulse(input string tag);
        rst = 1'b1;
        #2;
        chk({tag, "_q"}, bus.q, 0);
        chk({tag, "_wrap"}, bus.wrap, 0);
        chk({tag, "_ovf"}, bus.ovf_sticky, 0);
        chk({tag, "_sv"}, bus.snap_valid, 0);
        chk({tag, "_sd"}, bus.snap_data, 0);
        rst = 1'b0;
        #1;
        model_reset();
    endtask

    initial begin
        bus.en = 0; bus.control = 0; bus.load = 0; bus.load_val = '0;
        bus.clr_ovf = 0; bus.snap_req = 0; bus.snap_ack = 0;
        bus9.en = 0; bus9.control = 0; bus9.load = 0; bus9.load_val = '0;
        bus9.clr_ovf = 0; bus9.snap_req = 0; bus9.snap_ack = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_q", bus.q, 0);
        chk("rst_flags", {bus.wrap, bus.ovf_sticky, bus.snap_valid}, 0);
        chk("rst_sd", bus.snap_data, 0);
        rst = 1'b0;

        // 1: count a little, async reset mid-cycle, then 16 up edges wrap to 0
        for (int i = 0; i < 3; i++) step(1, 0, 0, '0, 0, 0, 0);
        chk("t1_pre_rst_q", bus.q, 3);
        rst_pulse("t1_rst");
        for (int i = 1; i <= 16; i++) begin
            step(1, 0, 0, '0, 0, 0, 0);
            chk("t1_q_seq", bus.q, i % 16);
        end
        chk("t1_wrap", bus.wrap, 1);
        chk("t1_ovf", bus.ovf_sticky, 1);
        step(0, 0, 0, '0, 0, 0, 0);
        chk("t1_wrap_1cyc", bus.wrap, 0);
        chk("t1_ovf_held", bus.ovf_sticky, 1);

        // 2: down from 0 wraps to 15, then 14; tc direction dependence at q=0
        step(1, 0, 1, 4'd0, 1, 0, 0);
        chk("t2_ovf_clr", bus.ovf_sticky, 0);
        step(1, 1, 0, '0, 0, 0, 0);
        chk("t2_q15", bus.q, 15);
        chk("t2_wrap", bus.wrap, 1);
        step(1, 1, 0, '0, 0, 0, 0);
        chk("t2_q14", bus.q, 14);
        step(0, 0, 1, 4'd0, 0, 0, 0);
        bus.load = 0; bus.control = 1; #1;
        chk("t2_tc_dn_q0", bus.tc, 1);
        bus.control = 0; #1;
        chk("t2_tc_up_q0", bus.tc, 0);

        // 3: load beats enable and never wraps, even at terminal count
        step(1, 0, 1, 4'd9, 0, 0, 0);
        chk("t3_load9", bus.q, 9);
        step(1, 0, 1, 4'd15, 0, 0, 0);
        step(1, 0, 1, 4'd2, 0, 0, 0);
        chk("t3_load_tc_q", bus.q, 2);
        chk("t3_load_nowrap", bus.wrap, 0);
        bus9.load = 1; bus9.load_val = 4'd13;
        @(posedge clk); #1;
        chk("t3_sat9", bus9.q, 9);
        bus9.load_val = 4'd5;
        @(posedge clk); #1;
        chk("t3_load5_max9", bus9.q, 5);
        bus9.load = 0; bus9.en = 1;
        for (int i = 0; i < 5; i++) begin @(posedge clk); #1; end
        chk("t3_wrap_max9_q", bus9.q, 0);
        chk("t3_wrap_max9", bus9.wrap, 1);
        bus9.en = 0;
        idle(1);

        // 4: set wins over clear, then clear alone
        step(0, 0, 1, 4'd15, 0, 0, 0);
        step(1, 0, 0, '0, 0, 0, 0);
        chk("t4_ovf_set", bus.ovf_sticky, 1);
        step(1, 0, 1, 4'd15, 0, 0, 0);
        step(1, 0, 0, '0, 1, 0, 0);
        chk("t4_set_wins", bus.ovf_sticky, 1);
        step(0, 0, 0, '0, 1, 0, 0);
        chk("t4_clr", bus.ovf_sticky, 0);

        // 5: snapshot while counting; frozen in HOLD; ack+req drops the request
        step(0, 0, 1, 4'd5, 0, 0, 1);
        chk("t5_ack_idle", bus.snap_valid, 0);
        step(1, 0, 0, '0, 0, 1, 0);
        chk("t5_sv", bus.snap_valid, 1);
        chk("t5_sd5", bus.snap_data, 5);
        step(1, 0, 0, '0, 0, 1, 0);
        step(1, 0, 0, '0, 0, 0, 0);
        chk("t5_q8", bus.q, 8);
        chk("t5_sd_frozen", bus.snap_data, 5);
        step(1, 0, 0, '0, 0, 1, 1);
        chk("t5_ack_sv", bus.snap_valid, 0);
        step(0, 0, 0, '0, 0, 0, 0);
        chk("t5_no_recapture", {bus.snap_valid, bus.snap_data}, {1'b0, 4'd5});

        // 6: reset during HOLD, then a normal capture
        step(0, 0, 1, 4'd11, 0, 1, 0);
        chk("t6_hold", bus.snap_valid, 1);
        rst_pulse("t6_rst");
        step(0, 0, 1, 4'd7, 0, 0, 0);
        step(1, 0, 0, '0, 0, 1, 0);
        chk("t6_recap", bus.snap_data, 7);
        step(0, 0, 0, '0, 0, 0, 1);

        // random mix against the model
        for (int i = 0; i < 300; i++)
            step(W'($urandom_range(0, 1)) != 0 || $urandom_range(0, 3) != 0,
                 1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0,
                 W'($urandom_range(0, 15)), $urandom_range(0, 5) == 0,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
